// File: rtl/gray_seq_gen_if.sv
// Control and code bus of the Gray-code sequence source.
// Master drives the controls, slave returns the registered codes.
interface gray_seq_gen_if #(
  parameter int WIDTH = 4
);
  logic             en_pi;
  logic             modo_pi;
  logic             dir_pi;
  logic             paso_pi;
  logic             carga_pi;
  logic [WIDTH-1:0] codigo_bin_pi;
  logic [WIDTH-1:0] codigo_gray_po;
  logic [WIDTH-1:0] codigo_bin_po;
  logic             cambio_po;

  modport master (
    output en_pi, modo_pi, dir_pi,
    output paso_pi, carga_pi, codigo_bin_pi,
    input  codigo_gray_po, codigo_bin_po,
    input  cambio_po
  );

  modport slave (
    input  en_pi, modo_pi, dir_pi,
    input  paso_pi, carga_pi, codigo_bin_pi,
    output codigo_gray_po, codigo_bin_po,
    output cambio_po
  );
endinterface

// File: rtl/gray_seq_gen.sv
// Gray-code sequence source: prescaled or single-step
// up/down counter with parallel load and registered Gray output.
module gray_seq_gen #(
  parameter int WIDTH    = 4,
  parameter int TICK_DIV = 27_000_000
) (
  input  logic         clk_pi,
  input  logic         rst_pi,
  gray_seq_gen_if.slave io
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_nxt;
  logic             s1;
  logic             s2;
  logic             s3;
  logic [WIDTH-1:0] bin;
  logic [WIDTH-1:0] gray;
  logic [WIDTH-1:0] bin_nxt;
  logic             cambio;
  logic             tick;
  logic             step;
  logic             adv;
  logic             ld;
  logic             up;
  logic             dn;

  assign tick = io.en_pi & io.modo_pi & (pre == PMAX);
  assign step = io.en_pi & ~io.modo_pi & s2 & ~s3;
  assign adv  = tick | step;
  // Load wins; a coinciding tick or step is dropped.
  assign ld   = io.carga_pi;
  assign up   = ~io.carga_pi & adv & ~io.dir_pi;
  assign dn   = ~io.carga_pi & adv & io.dir_pi;

  always_comb begin
    bin_nxt = bin;
    unique case (1'b1)
      ld:      bin_nxt = io.codigo_bin_pi;
      up:      bin_nxt = bin + WIDTH'(1);
      dn:      bin_nxt = bin - WIDTH'(1);
      default: bin_nxt = bin;
    endcase
  end

  always_comb begin
    pre_nxt = pre + PW'(1);
    if (io.carga_pi || !io.en_pi ||
        !io.modo_pi || pre == PMAX)
      pre_nxt = '0;
  end

  // Sync flops reset high so a held button gives no edge.
  always_ff @(posedge clk_pi) begin
    if (!rst_pi) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      s3     <= 1'b1;
      pre    <= '0;
      bin    <= '0;
      gray   <= '0;
      cambio <= 1'b0;
    end else begin
      s1     <= io.paso_pi;
      s2     <= s1;
      s3     <= s2;
      pre    <= pre_nxt;
      bin    <= bin_nxt;
      gray   <= bin_nxt ^ (bin_nxt >> 1);
      cambio <= ld | adv;
    end
  end

  assign io.codigo_bin_po  = bin;
  assign io.codigo_gray_po = gray;
  assign io.cambio_po      = cambio;
endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed bench for gray_seq_gen with TICK_DIV = 4.
// Expected codes are hand-derived or from a tiny Gray model.
module tb_gray_seq_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  gray_seq_gen_if #(.WIDTH(4)) io ();

  gray_seq_gen #(
    .WIDTH(4),
    .TICK_DIV(4)
  ) dut (
    .clk_pi(clk),
    .rst_pi(rst),
    .io(io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] first4 [4];
  logic [3:0] eb;
  logic [3:0] prev;

  initial begin
    first4[0] = 4'b0001;
    first4[1] = 4'b0011;
    first4[2] = 4'b0010;
    first4[3] = 4'b0110;
    io.en_pi = 1'b0;
    io.modo_pi = 1'b1;
    io.dir_pi = 1'b0;
    io.paso_pi = 1'b0;
    io.carga_pi = 1'b1;
    io.codigo_bin_pi = 4'b1010;

    // reset beats load
    edge1();
    edge1();
    chk("rst_gray", 32'(io.codigo_gray_po), 0);
    chk("rst_bin", 32'(io.codigo_bin_po), 0);
    chk("rst_cambio", 32'(io.cambio_po), 0);

    // auto up, full cycle
    io.carga_pi = 1'b0;
    io.en_pi = 1'b1;
    rst = 1'b1;
    eb = 4'd0;
    prev = 4'd0;
    for (int e = 1; e <= 64; e++) begin
      edge1();
      if (e % 4 == 0) begin
        eb = eb + 4'd1;
        if (e <= 16)
          chk("auto_tab", 32'(io.codigo_gray_po),
              32'(first4[e/4-1]));
        chk("auto_gray", 32'(io.codigo_gray_po), 32'(g(eb)));
        chk("auto_onebit",
            32'($countones(prev ^ io.codigo_gray_po)), 1);
        prev = io.codigo_gray_po;
      end
      chk("auto_bin", 32'(io.codigo_bin_po), 32'(eb));
      chk("auto_cambio", 32'(io.cambio_po),
          32'(e % 4 == 0));
    end
    chk("auto_back0", 32'(io.codigo_gray_po), 0);

    // wrap up and down
    io.carga_pi = 1'b1;
    io.codigo_bin_pi = 4'b1111;
    edge1();
    io.carga_pi = 1'b0;
    chk("ld_gray", 32'(io.codigo_gray_po), 32'b1000);
    chk("ld_bin", 32'(io.codigo_bin_po), 32'hf);
    chk("ld_cambio", 32'(io.cambio_po), 1);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("wrap_wait", 32'(io.cambio_po), 0);
    end
    edge1();
    chk("wrap_up_gray", 32'(io.codigo_gray_po), 0);
    chk("wrap_up_bin", 32'(io.codigo_bin_po), 0);
    io.dir_pi = 1'b1;
    for (int i = 0; i < 4; i++) edge1();
    chk("wrap_dn_gray", 32'(io.codigo_gray_po), 32'b1000);
    chk("wrap_dn_bin", 32'(io.codigo_bin_po), 32'hf);
    chk("wrap_dn_cambio", 32'(io.cambio_po), 1);

    // step mode: 10-cycle press, one advance at N+2
    io.modo_pi = 1'b0;
    io.dir_pi = 1'b0;
    edge1();
    io.paso_pi = 1'b1;
    edge1();
    chk("step_n", 32'(io.codigo_bin_po), 32'hf);
    edge1();
    chk("step_n1", 32'(io.codigo_bin_po), 32'hf);
    edge1();
    chk("step_n2_bin", 32'(io.codigo_bin_po), 0);
    chk("step_n2_gray", 32'(io.codigo_gray_po), 0);
    chk("step_n2_cambio", 32'(io.cambio_po), 1);
    for (int i = 0; i < 7; i++) begin
      edge1();
      chk("step_hold_cambio", 32'(io.cambio_po), 0);
    end
    io.paso_pi = 1'b0;
    for (int i = 0; i < 4; i++) edge1();
    chk("step_once", 32'(io.codigo_bin_po), 0);

    // button held through reset release
    io.paso_pi = 1'b1;
    rst = 1'b0;
    edge1();
    edge1();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      edge1();
      chk("rst_hold_cambio", 32'(io.cambio_po), 0);
    end
    chk("rst_hold_bin", 32'(io.codigo_bin_po), 0);
    io.paso_pi = 1'b0;

    // load coinciding with tick
    rst = 1'b0;
    io.modo_pi = 1'b1;
    edge1();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) edge1();
    chk("coll_pre", 32'(io.codigo_bin_po), 0);
    io.carga_pi = 1'b1;
    io.codigo_bin_pi = 4'b0110;
    edge1();
    io.carga_pi = 1'b0;
    chk("coll_gray", 32'(io.codigo_gray_po), 32'b0101);
    chk("coll_bin", 32'(io.codigo_bin_po), 32'b0110);
    chk("coll_cambio", 32'(io.cambio_po), 1);
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("coll_noextra", 32'(io.codigo_bin_po), 32'b0110);
    end
    edge1();
    chk("coll_next", 32'(io.codigo_gray_po), 32'b0100);

    // disable
    io.en_pi = 1'b0;
    for (int i = 0; i < 20; i++) begin
      edge1();
      chk("dis_gray", 32'(io.codigo_gray_po), 32'b0100);
      chk("dis_cambio", 32'(io.cambio_po), 0);
    end
    io.modo_pi = 1'b0;
    for (int p = 0; p < 2; p++) begin
      io.paso_pi = 1'b1;
      edge1();
      edge1();
      io.paso_pi = 1'b0;
      for (int i = 0; i < 4; i++) begin
        edge1();
        chk("dis_step", 32'(io.codigo_gray_po), 32'b0100);
        chk("dis_step_c", 32'(io.cambio_po), 0);
      end
    end
    io.en_pi = 1'b1;
    io.modo_pi = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge1();
      chk("reen_wait", 32'(io.cambio_po), 0);
    end
    edge1();
    chk("reen_gray", 32'(io.codigo_gray_po), 32'b1100);
    chk("reen_bin", 32'(io.codigo_bin_po), 32'b1000);
    chk("reen_cambio", 32'(io.cambio_po), 1);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
